// File: rtl/toss_pkg.sv
// ============================================================================
// Module      : toss_pkg
// Description : Shared constants and state type for the toss_stats block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toss_pkg;

    localparam int SYM_W    = 3;
    localparam int NUM_BINS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FROZEN = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/toss_run_detect.sv
// ============================================================================
// Module      : toss_run_detect
// Description : Tracks identical consecutive accepted symbols and pulses
//               run_hit when a run first reaches RUN_LEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toss_run_detect
    import toss_pkg::*;
#(
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [SYM_W-1:0] sym,
    input  logic             flush,
    output logic             run_hit,
    output logic [SYM_W-1:0] run_sym
);

    localparam logic [3:0] C_RUN_LEN = 4'(RUN_LEN);

    logic [SYM_W-1:0] r_last_sym;
    logic [3:0]       r_run_len;   // 0 means tracker empty

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_sym <= '0;
            r_run_len  <= '0;
            run_hit    <= 1'b0;
            run_sym    <= '0;
        end else begin
            run_hit <= 1'b0;
            if (flush) begin
                r_run_len <= '0;
            end else if (accept) begin
                if (r_run_len != 4'd0 && sym == r_last_sym) begin
                    // Length saturates, so the pulse fires once per run
                    if (r_run_len < C_RUN_LEN) begin
                        r_run_len <= r_run_len + 4'd1;
                        if (r_run_len + 4'd1 == C_RUN_LEN) begin
                            run_hit <= 1'b1;
                            run_sym <= sym;
                        end
                    end
                end else begin
                    r_last_sym <= sym;
                    r_run_len  <= 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/toss_stats.sv
// ============================================================================
// Module      : toss_stats
// Description : 8-bin symbol histogram over a fixed window with clear sweep,
//               registered read port and optional run detector
//               (enabled by defining TOSS_STATS_RUN_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toss_stats
    import toss_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int WINDOW  = 200,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    input  logic             clear,
    input  logic             rd_req,
    input  logic [SYM_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] total,
    output logic             done,
    output logic             busy,
    output logic             run_hit,
    output logic [SYM_W-1:0] run_sym
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WINDOW - 1);

    generate
        if (WINDOW < 1 || WINDOW > (2**CNT_W) - 1 || RUN_LEN < 2 || RUN_LEN > 15) begin : g_param_check
            $error("toss_stats: illegal WINDOW/RUN_LEN for CNT_W");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_bins [NUM_BINS];
    logic [SYM_W-1:0] r_sweep_idx;

    logic w_counting;
    logic w_flush;
    logic w_accept;

    assign w_counting = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign w_flush    = clear && (r_state != ST_CLEAR);
    // A sample arriving with clear is dropped
    assign w_accept   = sym_valid && w_counting && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sweep_idx <= '0;
            total       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else begin
            // Read sees bin contents from before this edge's update
            rd_valid <= rd_req && (r_state != ST_CLEAR);
            if (rd_req && r_state != ST_CLEAR) begin
                rd_data <= r_bins[rd_idx];
            end

            case (r_state)
                ST_IDLE, ST_ACTIVE, ST_FROZEN: begin
                    if (clear) begin
                        r_state     <= ST_CLEAR;
                        r_sweep_idx <= '0;
                        total       <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end else if (w_accept) begin
                        r_bins[sym_in] <= r_bins[sym_in] + CNT_W'(1);
                        total          <= total + CNT_W'(1);
                        if (total == C_LAST) begin
                            r_state <= ST_FROZEN;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_ACTIVE;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_bins[r_sweep_idx] <= '0;
                    r_sweep_idx         <= r_sweep_idx + 3'd1;
                    if (r_sweep_idx == 3'(NUM_BINS - 1)) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef TOSS_STATS_RUN_EN
    toss_run_detect #(
        .RUN_LEN (RUN_LEN)
    ) u_run_detect (
        .clk     (clk),
        .rst     (rst),
        .accept  (w_accept),
        .sym     (sym_in),
        .flush   (w_flush),
        .run_hit (run_hit),
        .run_sym (run_sym)
    );
`else
    logic w_unused;
    assign w_unused = w_flush;
    assign run_hit  = 1'b0;
    assign run_sym  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_toss_stats.sv
// ============================================================================
// Module      : tb_toss_stats
// Description : Directed self-checking bench for toss_stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toss_stats;

`ifdef TOSS_STATS_RUN_EN
    localparam bit RUN_EN = 1'b1;
`else
    localparam bit RUN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sym_in;
    logic       sym_valid;
    logic       clear;
    logic       rd_req;
    logic [2:0] rd_idx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] total;
    logic       done;
    logic       busy;
    logic       run_hit;
    logic [2:0] run_sym;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    toss_stats #(
        .CNT_W   (8),
        .WINDOW  (200),
        .RUN_LEN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .clear     (clear),
        .rd_req    (rd_req),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .total     (total),
        .done      (done),
        .busy      (busy),
        .run_hit   (run_hit),
        .run_sym   (run_sym)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic read_bin(input logic [2:0] idx, output logic [7:0] val, output logic vld);
        rd_req = 1'b1;
        rd_idx = idx;
        step();
        rd_req = 1'b0;
        val    = rd_data;
        vld    = rd_valid;
    endtask

    task automatic do_clear();
        int n = 0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL clear_timeout: busy=%0b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; sym_in = '0; sym_valid = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_idx = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk_cnt++; if (total !== 8'd0) $display("FAIL reset_total: got %0d expected 0", total); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); else pass_cnt++;
        chk_cnt++; if (rd_data !== 8'd0) $display("FAIL reset_rd_data: got %0d expected 0", rd_data); else pass_cnt++;
        chk_cnt++; if (run_hit !== 1'b0 || run_sym !== 3'd0)
            $display("FAIL reset_run: got hit=%0b sym=%0d expected 0/0", run_hit, run_sym); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [2:0] seq [5] = '{3'd2, 3'd2, 3'd5, 3'd7, 3'd2};
        logic [7:0] exp_bin [8] = '{8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
        logic [7:0] v;
        logic       vl;
        for (int i = 0; i < 5; i++) send(seq[i]);
        chk_cnt++; if (total !== 8'd5) $display("FAIL basic_total: got %0d expected 5", total); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done: got %0b expected 0", done); else pass_cnt++;
        for (int b = 0; b < 8; b++) begin
            read_bin(3'(b), v, vl);
            chk_cnt++;
            if (vl !== 1'b1 || v !== exp_bin[b])
                $display("FAIL basic_bin%0d: got valid=%0b data=%0d expected 1/%0d", b, vl, v, exp_bin[b]);
            else pass_cnt++;
        end
        step();
        chk_cnt++; if (rd_valid !== 1'b0) $display("FAIL basic_rd_pulse: got %0b expected 0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_run();
        logic [2:0] seq [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4};
        logic       exp_hit;
        do_clear();
        for (int i = 0; i < 6; i++) begin
            send(seq[i]);
            exp_hit = RUN_EN && (i == 3);
            chk_cnt++;
            if (run_hit !== exp_hit) $display("FAIL run_hit_s%0d: got %0b expected %0b", i + 1, run_hit, exp_hit);
            else pass_cnt++;
        end
        chk_cnt++;
        if (run_sym !== (RUN_EN ? 3'd1 : 3'd0)) $display("FAIL run_sym: got %0d expected %0d", run_sym, RUN_EN ? 1 : 0);
        else pass_cnt++;
        chk_cnt++; if (total !== 8'd6) $display("FAIL run_total: got %0d expected 6", total); else pass_cnt++;
    endtask

    task automatic test_coincident_read();
        logic [7:0] v;
        logic       vl;
        for (int i = 0; i < 4; i++) send(3'd6);
        sym_in = 3'd6; sym_valid = 1'b1; rd_req = 1'b1; rd_idx = 3'd6;
        step();
        sym_valid = 1'b0; rd_req = 1'b0;
        chk_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 8'd4)
            $display("FAIL coincident_read: got valid=%0b data=%0d expected 1/4", rd_valid, rd_data);
        else pass_cnt++;
        read_bin(3'd6, v, vl);
        chk_cnt++;
        if (vl !== 1'b1 || v !== 8'd5) $display("FAIL followup_read: got valid=%0b data=%0d expected 1/5", vl, v);
        else pass_cnt++;
    endtask

    task automatic test_window();
        logic [7:0] v;
        logic       vl;
        do_clear();
        for (int k = 1; k <= 210; k++) begin
            send(3'd3);
            if (k == 199) begin
                chk_cnt++; if (done !== 1'b0) $display("FAIL window_done_199: got %0b expected 0", done); else pass_cnt++;
            end
            if (k == 200) begin
                chk_cnt++;
                if (done !== 1'b1 || total !== 8'd200)
                    $display("FAIL window_done_200: got done=%0b total=%0d expected 1/200", done, total);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (done !== 1'b1 || total !== 8'd200)
            $display("FAIL window_frozen: got done=%0b total=%0d expected 1/200", done, total);
        else pass_cnt++;
        read_bin(3'd3, v, vl);
        chk_cnt++;
        if (vl !== 1'b1 || v !== 8'd200) $display("FAIL window_bin3: got valid=%0b data=%0d expected 1/200", vl, v);
        else pass_cnt++;
    endtask

    task automatic test_clear_frozen();
        int         busy_cycles = 0;
        logic [7:0] v;
        logic       vl;
        clear = 1'b1;
        step();
        clear  = 1'b0;
        rd_req = 1'b1;
        rd_idx = 3'd3;
        while (busy && busy_cycles < 20) begin
            step();
            busy_cycles++;
            chk_cnt++;
            if (rd_valid !== 1'b0) $display("FAIL sweep_rd_valid_c%0d: got %0b expected 0", busy_cycles, rd_valid);
            else pass_cnt++;
        end
        rd_req = 1'b0;
        chk_cnt++; if (busy_cycles != 8) $display("FAIL sweep_len: got %0d expected 8", busy_cycles); else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b0 || total !== 8'd0)
            $display("FAIL after_clear: got done=%0b total=%0d expected 0/0", done, total);
        else pass_cnt++;
        for (int b = 0; b < 8; b++) begin
            read_bin(3'(b), v, vl);
            chk_cnt++;
            if (vl !== 1'b1 || v !== 8'd0) $display("FAIL cleared_bin%0d: got valid=%0b data=%0d expected 1/0", b, vl, v);
            else pass_cnt++;
        end
    endtask

    task automatic test_rst_mid_sweep();
        logic [7:0] v;
        logic       vl;
        send(3'd5); send(3'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || total !== 8'd0 || done !== 1'b0 || rd_valid !== 1'b0 || run_hit !== 1'b0 || run_sym !== 3'd0)
            $display("FAIL rst_async: got busy=%0b total=%0d done=%0b rd_valid=%0b run_hit=%0b run_sym=%0d expected all 0",
                     busy, total, done, rd_valid, run_hit, run_sym);
        else pass_cnt++;
        step();
        rst = 1'b0;
        step();
        read_bin(3'd5, v, vl);
        chk_cnt++;
        if (vl !== 1'b1 || v !== 8'd0) $display("FAIL rst_bin5: got valid=%0b data=%0d expected 1/0", vl, v);
        else pass_cnt++;
        send(3'd0);
        chk_cnt++;
        if (total !== 8'd1 || busy !== 1'b0) $display("FAIL rst_resume: got total=%0d busy=%0b expected 1/0", total, busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_run();
        test_coincident_read();
        test_window();
        test_clear_frozen();
        test_rst_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
